// File: rtl/cpu_clock_switch.sv
// Glitch-free CLKCPU generator: divided turbo clock or resynchronised C7M, hot-switched on an idle bus.
// Define CPUCLK_DEBOUNCE_EN to route JP1 through the DEBOUNCE_LIMIT stability counter.
module cpu_clock_switch #(
    parameter int unsigned TURBO_DIV      = 1,
    parameter int unsigned DEBOUNCE_LIMIT = 2000000
) (
    input  logic       pll_inst1_CLKOUT0,
    input  logic       RESET_n,
    input  logic       C7M,
    input  logic       JP1,
    input  logic       AS_CPU_n,
    input  logic       DTACK_CPU_n,
    output logic       CLKCPU,
    output logic       SPEED_TURBO,
    output logic       SWITCH_BUSY,
    output logic [2:0] fsm_state
);

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_SLOW  = 3'd1;
    localparam logic [2:0] ST_TURBO = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_PARK  = 3'd4;

    localparam logic [7:0] HC_TERM = 8'(TURBO_DIV - 1);

    if (TURBO_DIV < 1 || TURBO_DIV > 255 || DEBOUNCE_LIMIT < 1 || DEBOUNCE_LIMIT > 2097151) begin : g_bad_param
        $error("cpu_clock_switch: TURBO_DIV or DEBOUNCE_LIMIT out of range");
    end

    logic c7m_m, c7m_s, c7m_d;
    logic jp1_m, jp1_s;
    logic as_m, as_s;
    logic dtack_m, dtack_s;

    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            c7m_m   <= 1'b0;
            c7m_s   <= 1'b0;
            c7m_d   <= 1'b0;
            jp1_m   <= 1'b0;
            jp1_s   <= 1'b0;
            as_m    <= 1'b0;
            as_s    <= 1'b0;
            dtack_m <= 1'b0;
            dtack_s <= 1'b0;
        end else begin
            c7m_m   <= C7M;
            c7m_s   <= c7m_m;
            c7m_d   <= c7m_s;
            jp1_m   <= JP1;
            jp1_s   <= jp1_m;
            as_m    <= AS_CPU_n;
            as_s    <= as_m;
            dtack_m <= DTACK_CPU_n;
            dtack_s <= dtack_m;
        end
    end

    logic [2:0] state;
    logic [2:0] state_n;
    logic       clk_n;
    logic       speed_n;
    logic [7:0] hcnt;
    logic [7:0] hcnt_n;
    logic [1:0] init_cnt;
    logic [1:0] init_n;
    logic       sw_state;

    logic       c7m_rise;
    logic       bus_idle;
    logic       turbo_term;
    logic       turbo_clk;
    logic [7:0] turbo_hcnt;
    logic       src_clk;
    logic       src_fall;

    assign c7m_rise   = c7m_s & ~c7m_d;
    assign bus_idle   = as_s & dtack_s;
    assign turbo_term = (hcnt == HC_TERM);
    assign turbo_clk  = turbo_term ? ~CLKCPU : CLKCPU;
    assign turbo_hcnt = turbo_term ? 8'd0 : hcnt + 8'd1;
    assign src_clk    = SPEED_TURBO ? turbo_clk : c7m_s;
    assign src_fall   = CLKCPU & ~src_clk;

    always_comb begin
        state_n = state;
        clk_n   = CLKCPU;
        speed_n = SPEED_TURBO;
        hcnt_n  = hcnt;
        init_n  = init_cnt;
        case (state)
            ST_INIT: begin
                clk_n  = 1'b0;
                hcnt_n = 8'd0;
                // Slow start waits for C7M low so the first CLKCPU high is a full C7M high.
                if (init_cnt != 2'd2) begin
                    init_n = init_cnt + 2'd1;
                end else if (jp1_s) begin
                    speed_n = 1'b1;
                    state_n = ST_TURBO;
                end else if (!c7m_s) begin
                    speed_n = 1'b0;
                    state_n = ST_SLOW;
                end
            end
            ST_SLOW: begin
                clk_n  = c7m_s;
                hcnt_n = 8'd0;
                if (sw_state) state_n = ST_DRAIN;
            end
            ST_TURBO: begin
                clk_n  = turbo_clk;
                hcnt_n = turbo_hcnt;
                if (!sw_state) state_n = ST_DRAIN;
            end
            ST_DRAIN: begin
                clk_n  = src_clk;
                hcnt_n = SPEED_TURBO ? turbo_hcnt : 8'd0;
                if (sw_state == SPEED_TURBO) begin
                    state_n = SPEED_TURBO ? ST_TURBO : ST_SLOW;
                end else if (bus_idle && src_fall) begin
                    state_n = ST_PARK;
                    clk_n   = 1'b0;
                    hcnt_n  = 8'd0;
                end
            end
            ST_PARK: begin
                // hcnt enforces TURBO_DIV low cycles before either source may raise CLKCPU.
                clk_n = 1'b0;
                if (hcnt != HC_TERM) begin
                    hcnt_n = hcnt + 8'd1;
                end else if (SPEED_TURBO) begin
                    if (c7m_rise) begin
                        clk_n   = 1'b1;
                        speed_n = 1'b0;
                        hcnt_n  = 8'd0;
                        state_n = ST_SLOW;
                    end
                end else begin
                    clk_n   = 1'b1;
                    speed_n = 1'b1;
                    hcnt_n  = 8'd0;
                    state_n = ST_TURBO;
                end
            end
            default: begin
                clk_n   = 1'b0;
                state_n = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= ST_INIT;
            CLKCPU      <= 1'b0;
            SPEED_TURBO <= 1'b0;
            SWITCH_BUSY <= 1'b0;
            hcnt        <= 8'd0;
            init_cnt    <= 2'd0;
        end else begin
            state       <= state_n;
            CLKCPU      <= clk_n;
            SPEED_TURBO <= speed_n;
            SWITCH_BUSY <= (state_n == ST_DRAIN) || (state_n == ST_PARK);
            hcnt        <= hcnt_n;
            init_cnt    <= init_n;
        end
    end

`ifdef CPUCLK_DEBOUNCE_EN
    localparam logic [20:0] DB_TERM = 21'(DEBOUNCE_LIMIT - 1);

    logic [20:0] db_cnt;
    logic        init_load;

    assign init_load = (state == ST_INIT) && (state_n != ST_INIT);

    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            sw_state <= 1'b0;
            db_cnt   <= 21'd0;
        end else if (init_load) begin
            sw_state <= jp1_s;
            db_cnt   <= 21'd0;
        end else if (state == ST_INIT || jp1_s == sw_state) begin
            db_cnt <= 21'd0;
        end else if (db_cnt == DB_TERM) begin
            sw_state <= jp1_s;
            db_cnt   <= 21'd0;
        end else begin
            db_cnt <= db_cnt + 21'd1;
        end
    end
`else
    always_ff @(posedge pll_inst1_CLKOUT0 or negedge RESET_n) begin
        if (!RESET_n) begin
            sw_state <= 1'b0;
        end else begin
            sw_state <= jp1_s;
        end
    end
`endif

    assign fsm_state = state;

endmodule

// File: tb/tb_cpu_clock_switch.sv
// Directed-plus-random bench for cpu_clock_switch: reset/INIT, turbo rate, C7M follow, hot switches, reverts, resets.
`timescale 1ns/1ps
module tb_cpu_clock_switch;

    localparam int TDIV = 2;
    localparam int DBL  = 100;
`ifdef CPUCLK_DEBOUNCE_EN
    localparam int ACC = DBL + 10;
`else
    localparam int ACC = 8;
`endif

    logic       clk;
    logic       RESET_n;
    logic       C7M;
    logic       JP1;
    logic       AS_CPU_n;
    logic       DTACK_CPU_n;
    logic       CLKCPU;
    logic       SPEED_TURBO;
    logic       SWITCH_BUSY;
    logic [2:0] fsm_state;

    int checks   = 0;
    int failures = 0;

    cpu_clock_switch #(
        .TURBO_DIV(TDIV),
        .DEBOUNCE_LIMIT(DBL)
    ) dut (
        .pll_inst1_CLKOUT0(clk),
        .RESET_n(RESET_n),
        .C7M(C7M),
        .JP1(JP1),
        .AS_CPU_n(AS_CPU_n),
        .DTACK_CPU_n(DTACK_CPU_n),
        .CLKCPU(CLKCPU),
        .SPEED_TURBO(SPEED_TURBO),
        .SWITCH_BUSY(SWITCH_BUSY),
        .fsm_state(fsm_state)
    );

    // Clock and reset-free stimulus sources
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // C7M edges fall on .25/.75 ns so they never coincide with a CLKOUT0 edge.
    initial begin
        C7M = 1'b0;
        #(0.25 + $urandom_range(0, 60));
        forever #70.5 C7M = ~C7M;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Reference: C7M as seen at the last three CLKOUT0 edges; CLKCPU in slow mode = C7M two edges back.
    logic [2:0] c7m_hist = 3'b000;
    always @(posedge clk) c7m_hist = {c7m_hist[1:0], C7M};

    bit slow_en  = 0;
    bit turbo_en = 0;
    logic [0:0] exp_q[$];
    int run = 0;
    bit run_ok = 0;
    logic prev_clk = 1'b0;
    int last_low = 0;

    always @(negedge clk) begin
        if (slow_en) check("slow_follow", {31'd0, CLKCPU}, {31'd0, c7m_hist[2]});
        if (turbo_en) begin
            if (exp_q.size() == TDIV) check("turbo_period", {31'd0, CLKCPU}, {31'd0, exp_q.pop_front()});
            exp_q.push_back(!CLKCPU);
        end else begin
            exp_q.delete();
        end
        if (!RESET_n) begin
            run_ok = 0;
            run = 0;
        end else if (CLKCPU === prev_clk) begin
            run++;
        end else begin
            if (run_ok) check("min_width", {31'd0, run >= TDIV}, 32'd1);
            if (prev_clk == 1'b0) last_low = run;
            run = 1;
            run_ok = 1;
        end
        prev_clk = CLKCPU;
    end

    task automatic wait_busy(input string tag, input int lim);
        int n = 0;
        while (SWITCH_BUSY !== 1'b1 && n < lim) begin tick(); n++; end
        check(tag, {31'd0, SWITCH_BUSY}, 32'd1);
    endtask

    task automatic wait_speed(input string tag, input logic want, input int lim);
        int n = 0;
        while ((SPEED_TURBO !== want || SWITCH_BUSY !== 1'b0) && n < lim) begin tick(); n++; end
        check({tag, "_speed"}, {31'd0, SPEED_TURBO}, {31'd0, want});
        check({tag, "_busy"}, {31'd0, SWITCH_BUSY}, 32'd0);
    endtask

    task automatic wait_fall(input int lim, output bit ok);
        logic p = CLKCPU;
        ok = 0;
        for (int n = 0; n < lim && !ok; n++) begin
            tick();
            if (p === 1'b1 && CLKCPU === 1'b0) ok = 1;
            p = CLKCPU;
        end
    endtask

    initial begin
        bit ok;
        int lows;
        logic mode;
        logic target;
        logic expc;
        bit saw;

        RESET_n = 1'b0;
        JP1 = 1'b1;
        AS_CPU_n = 1'b1;
        DTACK_CPU_n = 1'b1;
        repeat (3) tick();
        check("rst_clk", {31'd0, CLKCPU}, 32'd0);
        check("rst_speed", {31'd0, SPEED_TURBO}, 32'd0);
        check("rst_busy", {31'd0, SWITCH_BUSY}, 32'd0);

        // Turbo start: low through INIT, first rise 3+TDIV edges after release, half-period TDIV.
        RESET_n = 1'b1;
        for (int c = 1; c <= 3 + TDIV + 12; c++) begin
            tick();
            expc = (c < 3 + TDIV) ? 1'b0 : (((c - (3 + TDIV)) / TDIV) % 2 == 0);
            check("init_turbo_clk", {31'd0, CLKCPU}, {31'd0, expc});
            if (c >= 3 + TDIV) check("init_turbo_speed", {31'd0, SPEED_TURBO}, 32'd1);
            check("init_turbo_busy", {31'd0, SWITCH_BUSY}, 32'd0);
        end
        turbo_en = 1;
        repeat (20) tick();

        // Turbo -> slow with the bus held busy: turbo keeps running in DRAIN.
        AS_CPU_n = 1'b0;
        JP1 = 1'b0;
        wait_busy("t2s_busy", ACC + 4);
        repeat (30) tick();
        check("t2s_drain_speed", {31'd0, SPEED_TURBO}, 32'd1);
        check("t2s_drain_busy", {31'd0, SWITCH_BUSY}, 32'd1);
        turbo_en = 0;
        AS_CPU_n = 1'b1;
        wait_speed("t2s", 1'b0, 60);
        check("t2s_park_low_max", {31'd0, last_low <= 15 + 3 + TDIV}, 32'd1);
        check("t2s_park_low_min", {31'd0, last_low >= 1}, 32'd1);
        slow_en = 1;
        repeat (40) tick();

        // Slow DRAIN revert: CLKCPU must keep following C7M throughout.
        AS_CPU_n = 1'b0;
        JP1 = 1'b1;
        wait_busy("slow_rev_busy", ACC + 4);
        repeat (5) tick();
        JP1 = 1'b0;
        repeat (100 + ACC) tick();
        check("slow_rev_speed", {31'd0, SPEED_TURBO}, 32'd0);
        check("slow_rev_busy_end", {31'd0, SWITCH_BUSY}, 32'd0);
        AS_CPU_n = 1'b1;
        repeat (10) tick();
        slow_en = 0;

        // Slow -> turbo: PARK low is exactly TDIV cycles after the C7M-derived fall.
        JP1 = 1'b1;
        wait_busy("s2t_busy", ACC + 4);
        wait_fall(40, ok);
        check("s2t_fall_seen", {31'd0, ok}, 32'd1);
        lows = 1;
        while (CLKCPU === 1'b0 && lows < 50) begin tick(); if (CLKCPU === 1'b0) lows++; end
        check("s2t_park_low", lows, TDIV);
        check("s2t_speed", {31'd0, SPEED_TURBO}, 32'd1);
        tick();
        check("s2t_busy", {31'd0, SWITCH_BUSY}, 32'd0);
        turbo_en = 1;
        repeat (20) tick();

        // Turbo DRAIN revert: period must stay unbroken.
        AS_CPU_n = 1'b0;
        JP1 = 1'b0;
        wait_busy("turbo_rev_busy", ACC + 4);
        repeat (5) tick();
        JP1 = 1'b1;
        repeat (100 + ACC) tick();
        check("turbo_rev_speed", {31'd0, SPEED_TURBO}, 32'd1);
        check("turbo_rev_busy_end", {31'd0, SWITCH_BUSY}, 32'd0);
        AS_CPU_n = 1'b1;
        repeat (10) tick();
        turbo_en = 0;
        mode = 1'b1;

`ifdef CPUCLK_DEBOUNCE_EN
        // A JP1 glitch shorter than the debounce limit must be ignored.
        saw = 0;
        turbo_en = 1;
        JP1 = 1'b0;
        for (int i = 0; i < DBL / 2; i++) begin tick(); if (SWITCH_BUSY) saw = 1; end
        JP1 = 1'b1;
        for (int i = 0; i < DBL + 50; i++) begin tick(); if (SWITCH_BUSY) saw = 1; end
        check("glitch_busy", {31'd0, saw}, 32'd0);
        check("glitch_speed", {31'd0, SPEED_TURBO}, 32'd1);
        turbo_en = 0;
`else
        saw = 0;
`endif

        // Random switch sequence: the settled mode must match the last requested JP1.
        for (int it = 0; it < 8; it++) begin
            target = 1'($urandom_range(0, 1));
            AS_CPU_n = 1'b0;
            DTACK_CPU_n = 1'($urandom_range(0, 1));
            JP1 = target;
            repeat ($urandom_range(0, 30)) tick();
            AS_CPU_n = 1'b1;
            DTACK_CPU_n = 1'b1;
            wait_speed("rand", target, ACC + 80);
            mode = target;
            if (mode) turbo_en = 1; else slow_en = 1;
            repeat ($urandom_range(10, 40)) tick();
            turbo_en = 0;
            slow_en = 0;
        end

        // Reset landing in PARK: outputs clear asynchronously, then a clean INIT restart.
        if (mode == 1'b0) begin
            JP1 = 1'b1;
            wait_speed("pre_park", 1'b1, ACC + 80);
        end
        JP1 = 1'b0;
        wait_busy("park_busy", ACC + 4);
        wait_fall(4 * TDIV + 4, ok);
        check("park_fall_seen", {31'd0, ok}, 32'd1);
        check("park_busy_held", {31'd0, SWITCH_BUSY}, 32'd1);
        #2 RESET_n = 1'b0;
        #1;
        check("park_rst_clk", {31'd0, CLKCPU}, 32'd0);
        check("park_rst_busy", {31'd0, SWITCH_BUSY}, 32'd0);
        check("park_rst_speed", {31'd0, SPEED_TURBO}, 32'd1 - 32'd1);
        repeat (3) tick();
        RESET_n = 1'b1;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check("restart_init_clk", {31'd0, CLKCPU}, 32'd0);
        end
        wait_speed("restart_slow", 1'b0, 12);
        repeat (12) tick();
        slow_en = 1;
        repeat (30) tick();
        slow_en = 0;

        // Reset while CLKCPU is high in turbo drops it immediately.
        JP1 = 1'b1;
        wait_speed("pre_hi_rst", 1'b1, ACC + 80);
        for (int n = 0; n < 10 && CLKCPU !== 1'b1; n++) tick();
        check("hi_before_rst", {31'd0, CLKCPU}, 32'd1);
        #2 RESET_n = 1'b0;
        #1;
        check("hi_rst_clk", {31'd0, CLKCPU}, 32'd0);
        check("hi_rst_speed", {31'd0, SPEED_TURBO}, 32'd0);
        repeat (2) tick();
        RESET_n = 1'b1;
        repeat (10) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
